// File: rtl/register_file_sb_if.sv
// Register file bus: decode-side reads and load issue,
// execute/memory-side write and load-return ports.
interface register_file_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16,
  parameter int READ_PORTS = 3
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int HALF  = DATA_WIDTH / 2;

  logic                             write;
  logic                             write_immediate;
  logic [IDX_W-1:0]                 write_index;
  logic [DATA_WIDTH-1:0]            write_data;
  logic [HALF-1:0]                  write_immediate_data;
  logic [1:0]                       write_immediate_type;
  logic                             load_issue;
  logic [IDX_W-1:0]                 load_issue_index;
  logic                             load_complete;
  logic [IDX_W-1:0]                 load_index;
  logic [DATA_WIDTH-1:0]            load_data;
  logic [READ_PORTS*IDX_W-1:0]      read_index;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0]            read_busy;
  logic                             collision;
  logic                             issue_error;

  modport master (
    output write,
    output write_immediate,
    output write_index,
    output write_data,
    output write_immediate_data,
    output write_immediate_type,
    output load_issue,
    output load_issue_index,
    output load_complete,
    output load_index,
    output load_data,
    output read_index,
    input  read_data,
    input  read_busy,
    input  collision,
    input  issue_error
  );

  modport slave (
    input  write,
    input  write_immediate,
    input  write_index,
    input  write_data,
    input  write_immediate_data,
    input  write_immediate_type,
    input  load_issue,
    input  load_issue_index,
    input  load_complete,
    input  load_index,
    input  load_data,
    input  read_index,
    output read_data,
    output read_busy,
    output collision,
    output issue_error
  );
endinterface

// File: rtl/register_file_sb.sv
// Multi-port register file with per-register load busy
// scoreboard, immediate merge and optional write bypass.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16,
  parameter int READ_PORTS = 3,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  register_file_sb_if.slave   bus
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int H     = DATA_WIDTH / 2;

  localparam logic [1:0] IT_BOTTOM   = 2'd0;
  localparam logic [1:0] IT_TOP      = 2'd1;
  localparam logic [1:0] IT_UNSIGNED = 2'd2;
  localparam logic [1:0] IT_SIGNED   = 2'd3;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                regs_q [REG_COUNT];
  word_t                regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic                 collision_q;
  logic                 issue_error_q;

  logic                 wp_en;
  word_t                wp_old;
  word_t                wp_val;
  logic [H-1:0]         imm;
  logic                 err_set;
  logic                 coll_set;

  always_comb begin
    imm    = bus.write_immediate_data;
    wp_old = regs_q[bus.write_index];
    wp_en  = bus.write | bus.write_immediate;
    wp_val = wp_old;
    if (bus.write) begin
      wp_val = bus.write_data;
    end else begin
      unique case (bus.write_immediate_type)
        IT_BOTTOM:   wp_val = {wp_old[DATA_WIDTH-1:H], imm};
        IT_TOP:      wp_val = {imm, wp_old[H-1:0]};
        IT_UNSIGNED: wp_val = {{H{1'b0}}, imm};
        IT_SIGNED:   wp_val = {{H{imm[H-1]}}, imm};
      endcase
    end
  end

  // Write port overrides a same-index load return.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      regs_d[r] = regs_q[r];
      if (bus.load_complete &&
          bus.load_index == IDX_W'(r))
        regs_d[r] = bus.load_data;
      if (wp_en && bus.write_index == IDX_W'(r))
        regs_d[r] = wp_val;
    end
  end

  // A new issue wins over a same-index completion.
  always_comb begin
    busy_d = busy_q;
    if (bus.load_complete)
      busy_d[bus.load_index] = 1'b0;
    if (bus.load_issue)
      busy_d[bus.load_issue_index] = 1'b1;
  end

  assign err_set = bus.load_issue &&
                   busy_q[bus.load_issue_index] &&
                   !(bus.load_complete &&
                     bus.load_index == bus.load_issue_index);

  assign coll_set = wp_en && bus.load_complete &&
                    bus.write_index == bus.load_index;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++)
        regs_q[r] <= '0;
      busy_q        <= '0;
      collision_q   <= 1'b0;
      issue_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++)
        regs_q[r] <= regs_d[r];
      busy_q        <= busy_d;
      collision_q   <= coll_set;
      issue_error_q <= issue_error_q | err_set;
    end
  end

  logic [READ_PORTS*DATA_WIDTH-1:0] rd_flat;
  logic [READ_PORTS-1:0]            rb_flat;
  logic [IDX_W-1:0]                 ri;

  // Bypass reads simply look at next state.
  always_comb begin
    rd_flat = '0;
    rb_flat = '0;
    ri      = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      ri = bus.read_index[p*IDX_W +: IDX_W];
      if (BYPASS) begin
        rd_flat[p*DATA_WIDTH +: DATA_WIDTH] = regs_d[ri];
        rb_flat[p] = busy_d[ri];
      end else begin
        rd_flat[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ri];
        rb_flat[p] = busy_q[ri];
      end
    end
  end

  assign bus.read_data   = rd_flat;
  assign bus.read_busy   = rb_flat;
  assign bus.collision   = collision_q;
  assign bus.issue_error = issue_error_q;
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: 32-bit/16-reg/3-port unbypassed and
// 64-bit/32-reg/4-port bypassed register files.
module tb_register_file_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  register_file_sb_if #(
    .DATA_WIDTH(32), .REG_COUNT(16), .READ_PORTS(3)
  ) b32 ();
  register_file_sb_if #(
    .DATA_WIDTH(64), .REG_COUNT(32), .READ_PORTS(4)
  ) b64 ();

  register_file_sb #(
    .DATA_WIDTH(32), .REG_COUNT(16),
    .READ_PORTS(3), .BYPASS(1'b0)
  ) u32 (
    .clock(clk), .reset(rst_n), .bus(b32.slave)
  );

  register_file_sb #(
    .DATA_WIDTH(64), .REG_COUNT(32),
    .READ_PORTS(4), .BYPASS(1'b1)
  ) u64 (
    .clock(clk), .reset(rst_n), .bus(b64.slave)
  );

  task automatic idle32();
    b32.write = 0; b32.write_immediate = 0;
    b32.write_index = 0; b32.write_data = 0;
    b32.write_immediate_data = 0;
    b32.write_immediate_type = 0;
    b32.load_issue = 0; b32.load_issue_index = 0;
    b32.load_complete = 0; b32.load_index = 0;
    b32.load_data = 0;
  endtask

  task automatic idle64();
    b64.write = 0; b64.write_immediate = 0;
    b64.write_index = 0; b64.write_data = 0;
    b64.write_immediate_data = 0;
    b64.write_immediate_type = 0;
    b64.load_issue = 0; b64.load_issue_index = 0;
    b64.load_complete = 0; b64.load_index = 0;
    b64.load_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b32.read_index = {4'd2, 4'd1, 4'd0};
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (b32.read_data[p*32 +: 32] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_rd%0d got %h want 0",
                 p, b32.read_data[p*32 +: 32]);
      end
    end
    n_cmp++;
    if ({b32.read_busy, b32.collision, b32.issue_error}
        !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0",
               {b32.read_busy, b32.collision,
                b32.issue_error});
    end
  endtask

  task automatic test_immediate();
    logic [31:0] exp [5];
    logic [1:0]  typ [4];
    logic [15:0] val [4];
    exp = '{32'hdeadbeef, 32'hdeaddead, 32'hbeefdead,
            32'h00001234, 32'hffffffff};
    typ = '{2'd0, 2'd1, 2'd2, 2'd3};
    val = '{16'hdead, 16'hbeef, 16'h1234, 16'hffff};
    b32.read_index = {4'd1, 4'd0, 4'd2};
    idle32();
    b32.write = 1; b32.write_index = 2;
    b32.write_data = 32'hdeadbeef;
    step();
    n_cmp++;
    if (b32.read_data[31:0] !== exp[0]) begin
      n_bad++;
      $display("FAIL imm_full got %h want %h",
               b32.read_data[31:0], exp[0]);
    end
    for (int i = 0; i < 4; i++) begin
      idle32();
      b32.write_immediate = 1; b32.write_index = 2;
      b32.write_immediate_type = typ[i];
      b32.write_immediate_data = val[i];
      step();
      n_cmp++;
      if (b32.read_data[31:0] !== exp[i+1]) begin
        n_bad++;
        $display("FAIL imm_%0d got %h want %h", i,
                 b32.read_data[31:0], exp[i+1]);
      end
    end
    idle32();
    b32.write = 1; b32.write_immediate = 1;
    b32.write_index = 2; b32.write_data = 32'h0badf00d;
    b32.write_immediate_type = 2'd2;
    b32.write_immediate_data = 16'h7777;
    step();
    n_cmp++;
    if (b32.read_data !== {64'h0, 32'h0badf00d}) begin
      n_bad++;
      $display("FAIL write_wins got %h want %h",
               b32.read_data, {64'h0, 32'h0badf00d});
    end
    idle32();
  endtask

  task automatic test_load();
    b32.read_index = {4'd0, 4'd7, 4'd0};
    idle32();
    b32.load_issue = 1; b32.load_issue_index = 7;
    step();
    n_cmp++;
    if (b32.read_busy !== 3'b010) begin
      n_bad++;
      $display("FAIL load_busy got %b want 010",
               b32.read_busy);
    end
    idle32();
    b32.load_complete = 1; b32.load_index = 7;
    b32.load_data = 32'h12345678;
    step();
    n_cmp++;
    if (b32.read_data[63:32] !== 32'h12345678 ||
        b32.read_busy !== 3'b000) begin
      n_bad++;
      $display("FAIL load_done got %h/%b want 12345678/000",
               b32.read_data[63:32], b32.read_busy);
    end
    idle32();
  endtask

  task automatic test_collision();
    b32.read_index = {4'd4, 4'd9, 4'd8};
    idle32();
    b32.load_issue = 1; b32.load_issue_index = 4;
    step();
    idle32();
    b32.write = 1; b32.write_index = 4;
    b32.write_data = 32'h1;
    b32.load_complete = 1; b32.load_index = 4;
    b32.load_data = 32'h2;
    n_cmp++;
    if (b32.collision !== 1'b0) begin
      n_bad++;
      $display("FAIL coll_early got %b want 0",
               b32.collision);
    end
    step();
    n_cmp++;
    if (b32.read_data[95:64] !== 32'h1 ||
        b32.read_busy[2] !== 1'b0 ||
        b32.collision !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_edge got %h/%b/%b want 1/0/1",
               b32.read_data[95:64], b32.read_busy[2],
               b32.collision);
    end
    idle32();
    b32.write = 1; b32.write_index = 8;
    b32.write_data = 32'haaaa5555;
    b32.load_complete = 1; b32.load_index = 9;
    b32.load_data = 32'h5555aaaa;
    step();
    n_cmp++;
    if (b32.collision !== 1'b0 ||
        b32.read_data[63:0] !== 64'h5555aaaa_aaaa5555) begin
      n_bad++;
      $display("FAIL dual_commit got %b/%h want 0/%h",
               b32.collision, b32.read_data[63:0],
               64'h5555aaaa_aaaa5555);
    end
    idle32();
  endtask

  task automatic test_issue_error();
    b32.read_index = {4'd0, 4'd0, 4'd3};
    idle32();
    b32.load_issue = 1; b32.load_issue_index = 3;
    step();
    b32.load_complete = 1; b32.load_index = 3;
    b32.load_data = 32'h33;
    step();
    n_cmp++;
    if (b32.read_busy[0] !== 1'b1 ||
        b32.issue_error !== 1'b0 ||
        b32.read_data[31:0] !== 32'h33) begin
      n_bad++;
      $display("FAIL issue_cpl got %b/%b/%h want 1/0/33",
               b32.read_busy[0], b32.issue_error,
               b32.read_data[31:0]);
    end
    idle32();
    b32.load_issue = 1; b32.load_issue_index = 3;
    step();
    n_cmp++;
    if (b32.issue_error !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_err got %b want 1",
               b32.issue_error);
    end
    idle32();
    b32.load_complete = 1; b32.load_index = 3;
    step();
    idle32();
    step();
    n_cmp++;
    if (b32.issue_error !== 1'b1 ||
        b32.read_busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL issue_sticky got %b/%b want 1/0",
               b32.issue_error, b32.read_busy[0]);
    end
  endtask

  task automatic test_async_reset();
    b32.read_index = {4'd0, 4'd5, 4'd2};
    idle32();
    b32.write = 1; b32.write_index = 2;
    b32.write_data = 32'hdeadbeef;
    b32.load_issue = 1; b32.load_issue_index = 5;
    step();
    idle32();
    n_cmp++;
    if (b32.read_data[31:0] !== 32'hdeadbeef ||
        b32.read_busy[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset got %h/%b want deadbeef/1",
               b32.read_data[31:0], b32.read_busy[1]);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if (b32.read_data !== 96'h0 ||
        b32.read_busy !== 3'b0 ||
        b32.issue_error !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got %h/%b/%b want 0",
               b32.read_data, b32.read_busy,
               b32.issue_error);
    end
    #1;
    rst_n = 1;
    b32.write = 1; b32.write_index = 1;
    b32.write_data = 32'h55;
    b32.read_index = {4'd0, 4'd1, 4'd2};
    step();
    n_cmp++;
    if (b32.read_data[63:32] !== 32'h55) begin
      n_bad++;
      $display("FAIL post_reset got %h want 55",
               b32.read_data[63:32]);
    end
    idle32();
  endtask

  task automatic test_no_bypass();
    b32.read_index = {4'd0, 4'd0, 4'd6};
    idle32();
    b32.write = 1; b32.write_index = 6;
    b32.write_data = 32'h66;
    #1;
    n_cmp++;
    if (b32.read_data[31:0] !== 32'h0) begin
      n_bad++;
      $display("FAIL nobyp_early got %h want 0",
               b32.read_data[31:0]);
    end
    step();
    idle32();
  endtask

  task automatic test_bypass64();
    b64.read_index = {5'd0, 5'd10, 5'd12, 5'd31};
    idle64();
    b64.write = 1; b64.write_index = 31;
    b64.write_data = 64'hcafef00d_01234567;
    #1;
    n_cmp++;
    if (b64.read_data[63:0] !== 64'hcafef00d_01234567) begin
      n_bad++;
      $display("FAIL byp_same got %h want cafef00d01234567",
               b64.read_data[63:0]);
    end
    step();
    idle64();
    n_cmp++;
    if (b64.read_data[63:0] !== 64'hcafef00d_01234567) begin
      n_bad++;
      $display("FAIL byp_stored got %h want cafef00d01234567",
               b64.read_data[63:0]);
    end
    b64.write_immediate = 1; b64.write_index = 31;
    b64.write_immediate_type = 2'd3;
    b64.write_immediate_data = 32'h80000000;
    #1;
    n_cmp++;
    if (b64.read_data[63:0] !== 64'hffffffff_80000000) begin
      n_bad++;
      $display("FAIL byp_signed got %h want ffffffff80000000",
               b64.read_data[63:0]);
    end
    step();
    idle64();
    b64.load_issue = 1; b64.load_issue_index = 10;
    b64.write = 1; b64.write_index = 12;
    b64.write_data = 64'h1;
    b64.load_complete = 1; b64.load_index = 12;
    b64.load_data = 64'h2;
    #1;
    n_cmp++;
    if (b64.read_busy !== 4'b0100 ||
        b64.read_data[127:64] !== 64'h1) begin
      n_bad++;
      $display("FAIL byp_prio got %b/%h want 0100/1",
               b64.read_busy, b64.read_data[127:64]);
    end
    step();
    idle64();
    n_cmp++;
    if (b64.collision !== 1'b1 ||
        b64.read_data[63:0] !== 64'hffffffff_80000000) begin
      n_bad++;
      $display("FAIL byp_coll got %b/%h want 1",
               b64.collision, b64.read_data[63:0]);
    end
  endtask

  initial begin
    idle32();
    idle64();
    b32.read_index = '0;
    b64.read_index = '0;
    #2;
    test_reset();
    step();
    step();
    rst_n = 1;
    step();
    test_reset();
    test_immediate();
    test_load();
    test_collision();
    test_issue_error();
    test_async_reset();
    test_no_bypass();
    test_bypass64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
